drygascon128_seq: RTL and testbench

- Command-driven sequencer for the drygascon128 F/G core's 32-bit word port.
- Accepts commands and data words over valid/ready streams and issues the exact wr_c/wr_x/wr_i/start/rd_r/rd_c pulse sequences the core needs.
- Waits for round completion, then streams results out with backpressure.
- Sits between the AEAD mode FSM and one drygascon128 instance; it is the only driver of that instance.

---
 rtl/drygascon128_seq_if.sv | 26 ++
 rtl/drygascon128_seq.sv | 186 ++++++++++++++++++
 tb/tb_drygascon128_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drygascon128_seq_if.sv
// rtl/drygascon128_seq_if.sv - command, data-in, data-out and status bundle of the drygascon128 sequencer
interface drygascon128_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_ds;
    logic [3:0]  cmd_rounds;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        err;

    modport master (
        output cmd_valid, cmd_op, cmd_ds, cmd_rounds, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data, busy, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ds, cmd_rounds, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data, busy, err
    );
endinterface

// File: rtl/drygascon128_seq.sv
// rtl/drygascon128_seq.sv - command sequencer driving the word port of one drygascon128 F/G core
module drygascon128_seq #(
    parameter int IDLE_TIMEOUT = 255,
    parameter int DEF_ROUNDS   = 7
) (
    input  logic               clk,
    input  logic               rst,
    drygascon128_seq_if.slave  bus,
    output logic               o_core_rst,
    output logic               o_core_clk_en,
    output logic [31:0]        o_core_din,
    output logic [3:0]         o_core_ds,
    output logic               o_core_wr_i,
    output logic               o_core_wr_c,
    output logic               o_core_wr_x,
    output logic [3:0]         o_core_rounds,
    output logic               o_core_start,
    output logic               o_core_rd_r,
    output logic               o_core_rd_c,
    input  logic [31:0]        i_core_dout,
    input  logic               i_core_idle
);
    typedef enum logic [3:0] {
        S_IDLE, S_WC, S_WX, S_WI, S_START, S_ARM, S_WAIT, S_RD, S_CAP, S_OUT, S_DONE
    } state_t;

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_busy;
    logic        r_err;
    logic [1:0]  r_op;
    logic [3:0]  r_ds;
    logic [3:0]  r_rounds;
    logic [3:0]  r_cnt;
    logic [7:0]  r_tmo;
    logic        r_start;
    logic        r_rd_r;
    logic        r_rd_c;

    logic        w_cmd_fire;
    logic        w_in_fire;
    logic [3:0]  w_last;

    assign w_cmd_fire = bus.cmd_valid & r_cmd_ready;
    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_last     = (r_op == 2'd3) ? 4'd9 : 4'd3;

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;

    // The core shares our reset so its internal word counter restarts together with ours.
    assign o_core_rst    = rst;
    assign o_core_clk_en = 1'b1;
    assign o_core_din    = bus.in_data;
    assign o_core_ds     = r_ds;
    assign o_core_rounds = r_rounds;
    assign o_core_wr_c   = (r_state == S_WC) & w_in_fire;
    assign o_core_wr_x   = (r_state == S_WX) & w_in_fire;
    assign o_core_wr_i   = (r_state == S_WI) & w_in_fire;
    assign o_core_start  = r_start;
    assign o_core_rd_r   = r_rd_r;
    assign o_core_rd_c   = r_rd_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_op        <= '0;
            r_ds        <= '0;
            r_rounds    <= '0;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_start     <= 1'b0;
            r_rd_r      <= 1'b0;
            r_rd_c      <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_rd_r  <= 1'b0;
            r_rd_c  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_fire) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_op        <= bus.cmd_op;
                        r_ds        <= bus.cmd_ds;
                        r_rounds    <= (bus.cmd_rounds == 4'd0) ? 4'(DEF_ROUNDS) : bus.cmd_rounds;
                        r_cnt       <= '0;
                        case (bus.cmd_op)
                            2'd0: begin r_state <= S_WC;    r_in_ready <= 1'b1; end
                            2'd1: begin r_state <= S_WI;    r_in_ready <= 1'b1; end
                            2'd2: begin r_state <= S_START; r_start    <= 1'b1; end
                            default: begin r_state <= S_RD; r_rd_c     <= 1'b1; end
                        endcase
                    end
                end
                S_WC: if (w_in_fire) begin
                    if (r_cnt == 4'd9) begin
                        r_cnt   <= '0;
                        r_state <= S_WX;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_WX: if (w_in_fire) begin
                    if (r_cnt == 4'd3) begin
                        r_in_ready <= 1'b0;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_WI: if (w_in_fire) begin
                    if (r_cnt == 4'd3) begin
                        r_in_ready <= 1'b0;
                        r_start    <= 1'b1;
                        r_state    <= S_START;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_START: begin
                    r_tmo   <= '0;
                    r_state <= S_ARM;
                end
                // core_idle is still high here from before the start, so it is not looked at.
                S_ARM: begin
                    r_tmo   <= r_tmo + 8'd1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_core_idle) begin
                        if (r_op == 2'd2) begin
                            r_cnt   <= '0;
                            r_rd_r  <= 1'b1;
                            r_state <= S_RD;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else if (r_tmo == 8'(IDLE_TIMEOUT)) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                S_RD: r_state <= S_CAP;
                S_CAP: begin
                    r_out_data  <= i_core_dout;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    if (r_cnt == w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                        r_rd_r  <= (r_op == 2'd2);
                        r_rd_c  <= (r_op == 2'd3);
                        r_state <= S_RD;
                    end
                end
                S_DONE: begin
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_drygascon128_seq.sv
// tb/tb_drygascon128_seq.sv - self-checking bench for drygascon128_seq with a behavioural core stub
module tb_drygascon128_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    drygascon128_seq_if bus();

    logic        core_rst, core_clk_en, core_wr_i, core_wr_c, core_wr_x;
    logic        core_start, core_rd_r, core_rd_c;
    logic [31:0] core_din;
    logic [31:0] core_dout;
    logic [3:0]  core_ds, core_rounds;
    logic        core_idle;

    drygascon128_seq dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .o_core_rst    (core_rst),
        .o_core_clk_en (core_clk_en),
        .o_core_din    (core_din),
        .o_core_ds     (core_ds),
        .o_core_wr_i   (core_wr_i),
        .o_core_wr_c   (core_wr_c),
        .o_core_wr_x   (core_wr_x),
        .o_core_rounds (core_rounds),
        .o_core_start  (core_start),
        .o_core_rd_r   (core_rd_r),
        .o_core_rd_c   (core_rd_c),
        .i_core_dout   (core_dout),
        .i_core_idle   (core_idle)
    );

    int vecs = 0;
    int bad  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Core stub: word-addressed C/X/I/R registers, registered read data, idle low while running.
    logic [31:0] c_m[10];
    logic [31:0] x_m[4];
    logic [31:0] i_m[4];
    logic [31:0] r_m[4];
    int          wc, wx, wi, rr, rc, rcnt;
    logic [31:0] s_dout = '0;
    logic        s_idle = 1'b1;
    logic        pend = 1'b0, run = 1'b0;
    logic [3:0]  sds = '0, srnd = '0;
    bit          stuck = 1'b0;

    assign core_dout = s_dout;
    assign core_idle = s_idle;

    always @(posedge clk) begin
        if (core_rst) begin
            wc <= 0; wx <= 0; wi <= 0; rr <= 0; rc <= 0; rcnt <= 0;
            s_dout <= '0; s_idle <= 1'b1; pend <= 1'b0; run <= 1'b0;
        end else begin
            if (core_wr_c) begin c_m[wc] <= core_din; wc <= (wc == 9) ? 0 : wc + 1; end
            if (core_wr_x) begin x_m[wx] <= core_din; wx <= (wx == 3) ? 0 : wx + 1; end
            if (core_wr_i) begin i_m[wi] <= core_din; wi <= (wi == 3) ? 0 : wi + 1; end
            if (core_rd_c) begin s_dout <= c_m[rc]; rc <= (rc == 9) ? 0 : rc + 1; end
            if (core_rd_r) begin s_dout <= r_m[rr]; rr <= (rr == 3) ? 0 : rr + 1; end
            if (core_start) begin pend <= 1'b1; sds <= core_ds; srnd <= core_rounds; end
            if (pend) begin
                pend <= 1'b0; s_idle <= 1'b0; run <= 1'b1; rcnt <= int'(srnd);
            end else if (run && !stuck) begin
                if (rcnt != 0) rcnt <= rcnt - 1;
                else begin
                    run <= 1'b0;
                    s_idle <= 1'b1;
                    for (int k = 0; k < 4; k++)
                        r_m[k] <= c_m[k] ^ x_m[k] ^ i_m[k] ^ {sds, srnd, 24'(k)};
                end
            end
        end
    end

    int cyc = 0;
    int n_wrc = 0, n_wrx = 0, n_wri = 0, n_start = 0, n_rdr = 0, n_rdc = 0;
    int n_acc = 0, n_multi = 0, n_rdy_busy = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_wr_c) n_wrc <= n_wrc + 1;
        if (core_wr_x) n_wrx <= n_wrx + 1;
        if (core_wr_i) n_wri <= n_wri + 1;
        if (core_start) n_start <= n_start + 1;
        if (core_rd_r) n_rdr <= n_rdr + 1;
        if (core_rd_c) n_rdc <= n_rdc + 1;
        if (bus.cmd_valid && bus.cmd_ready) n_acc <= n_acc + 1;
        if ($countones({core_wr_c, core_wr_x, core_wr_i, core_start, core_rd_r, core_rd_c}) > 1)
            n_multi <= n_multi + 1;
        if (bus.cmd_ready && bus.busy) n_rdy_busy <= n_rdy_busy + 1;
    end

    logic p_idle = 1'b1, p_busy = 1'b0, p_err = 1'b0, p_rdy = 1'b0;
    int idle_rise = 0, busy_fall = 0, start_cyc = 0, err_rise = 0, rdy_rise = 0;
    always @(negedge clk) begin
        p_idle <= core_idle; p_busy <= bus.busy; p_err <= bus.err; p_rdy <= bus.cmd_ready;
        if (core_idle && !p_idle) idle_rise <= cyc;
        if (!bus.busy && p_busy) busy_fall <= cyc;
        if (bus.err && !p_err) err_rise <= cyc;
        if (bus.cmd_ready && !p_rdy) rdy_rise <= cyc;
        if (core_start) start_cyc <= cyc;
    end

    // Reference: what the bench has written, and what the core's R must be from it.
    logic [31:0] mc[10];
    logic [31:0] mx[4];
    logic [31:0] mi[4];
    logic [3:0]  mds, mrnd;

    function automatic logic [31:0] exp_r(input int i);
        return mc[i] ^ mx[i] ^ mi[i] ^ {mds, mrnd, 24'(i)};
    endfunction

    task automatic issue(input logic [1:0] op, input logic [3:0] ds, input logic [3:0] rn);
        int n = 0;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_ds = ds; bus.cmd_rounds = rn;
        while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.cmd_ready) chk("cmd_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic put_words(input int n, input logic [31:0] w[14], input bit gaps);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            bus.in_valid = 1'b1; bus.in_data = w[k];
            while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
            if (!bus.in_ready) chk("in_accept_timeout", 32'd0, 32'd1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic get_words(input int n, input bit rnd, output logic [31:0] got[10]);
        int k = 0, t = 0;
        for (int j = 0; j < 10; j++) got[j] = '0;
        while (k < n && t < 2000) begin
            bus.out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (bus.out_valid && bus.out_ready) begin got[k] = bus.out_data; k++; end
            @(negedge clk);
            t++;
        end
        bus.out_ready = 1'b0;
        if (k < n) chk("out_words_timeout", 32'(k), 32'(n));
    endtask

    task automatic wait_done();
        int t = 0;
        while (!bus.cmd_ready && t < 600) begin @(negedge clk); t++; end
        if (!bus.cmd_ready) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic load_cx(input logic [31:0] w[14], input bit gaps);
        issue(2'd0, 4'd0, 4'd0);
        put_words(14, w, gaps);
        wait_done();
        for (int k = 0; k < 10; k++) mc[k] = w[k];
        for (int k = 0; k < 4; k++) mx[k] = w[10 + k];
    endtask

    task automatic absorb(input logic [3:0] ds, input logic [3:0] rn, input logic [31:0] w[14]);
        issue(2'd1, ds, rn);
        put_words(4, w, 1'b1);
        wait_done();
        for (int k = 0; k < 4; k++) mi[k] = w[k];
    endtask

    task automatic read_c_check(input string name, input bit rnd);
        logic [31:0] got[10];
        int rd0 = n_rdc;
        issue(2'd3, 4'd0, 4'd0);
        get_words(10, rnd, got);
        wait_done();
        for (int k = 0; k < 10; k++) chk($sformatf("%s_c%0d", name, k), got[k], mc[k]);
        chk({name, "_rdc_count"}, 32'(n_rdc - rd0), 32'd10);
    endtask

    task automatic squeeze_check(input string name, input logic [3:0] ds, input logic [3:0] rn, input bit rnd);
        logic [31:0] got[10];
        int rd0 = n_rdr;
        issue(2'd2, ds, rn);
        mds = ds; mrnd = (rn == 4'd0) ? 4'd7 : rn;
        get_words(4, rnd, got);
        wait_done();
        for (int k = 0; k < 4; k++) chk($sformatf("%s_r%0d", name, k), got[k], exp_r(k));
        chk({name, "_rdr_count"}, 32'(n_rdr - rd0), 32'd4);
    endtask

    typedef struct {
        logic [3:0] ds;
        logic [3:0] rn;
        logic [3:0] exp_rn;
    } abs_vec_t;

    initial begin
        abs_vec_t    tbl[5];
        logic [31:0] w[14];
        logic [31:0] got[10];
        logic [31:0] held;
        int          a0, s0, i0, r0, c0, t, chg;

        tbl[0] = '{4'h1, 4'd0,  4'd7};
        tbl[1] = '{4'hA, 4'd1,  4'd1};
        tbl[2] = '{4'h5, 4'd11, 4'd11};
        tbl[3] = '{4'hF, 4'd15, 4'd15};
        tbl[4] = '{4'h0, 4'd0,  4'd7};

        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_ds = '0; bus.cmd_rounds = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        for (int k = 0; k < 14; k++) w[k] = '0;

        repeat (3) @(negedge clk);
        chk("rst_status", {27'd0, bus.cmd_ready, bus.in_ready, bus.out_valid, bus.busy, bus.err}, 32'd0);
        chk("rst_strobes", {26'd0, core_wr_c, core_wr_x, core_wr_i, core_start, core_rd_r, core_rd_c}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_core", {30'd0, core_rst, core_clk_en}, 32'd3);
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", {31'd0, bus.cmd_ready}, 32'd1);

        // Words offered while idle must not be taken.
        a0 = n_wrc + n_wrx + n_wri;
        bus.in_valid = 1'b1; bus.in_data = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("idle_no_writes", 32'(n_wrc + n_wrx + n_wri - a0), 32'd0);

        // LOAD_CX with 0..13 then READ_C.
        for (int k = 0; k < 14; k++) w[k] = 32'(k);
        a0 = n_wrc; s0 = n_wrx;
        load_cx(w, 1'b0);
        chk("load_wrc_count", 32'(n_wrc - a0), 32'd10);
        chk("load_wrx_count", 32'(n_wrx - s0), 32'd4);
        for (int k = 0; k < 4; k++) chk($sformatf("load_x%0d", k), x_m[k], 32'(10 + k));
        chk("load_busy", {31'd0, bus.busy}, 32'd0);
        read_c_check("readc0", 1'b0);

        // ABSORB domain/rounds table.
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 4; k++)
                w[k] = (v == 0) ? 32'h11111111 * 32'(k + 1) : $urandom;
            s0 = n_start; i0 = n_wri;
            absorb(tbl[v].ds, tbl[v].rn, w);
            chk($sformatf("abs%0d_starts", v), 32'(n_start - s0), 32'd1);
            chk($sformatf("abs%0d_wri", v), 32'(n_wri - i0), 32'd4);
            chk($sformatf("abs%0d_ds", v), {28'd0, sds}, {28'd0, tbl[v].ds});
            chk($sformatf("abs%0d_rounds", v), {28'd0, srnd}, {28'd0, tbl[v].exp_rn});
            for (int k = 0; k < 4; k++) chk($sformatf("abs%0d_i%0d", v, k), i_m[k], w[k]);
            chk($sformatf("abs%0d_busy_after_idle", v), 32'(busy_fall - idle_rise), 32'd2);
        end

        // SQUEEZE rounds=11 with 20 stalled cycles on the first word.
        r0 = n_rdr;
        issue(2'd2, 4'h3, 4'd11);
        mds = 4'h3; mrnd = 4'd11;
        t = 0;
        while (!bus.out_valid && t < 200) begin @(negedge clk); t++; end
        chk("sq_first_valid", {31'd0, bus.out_valid}, 32'd1);
        held = bus.out_data;
        chg = 0;
        repeat (20) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_data !== held) chg++;
        end
        chk("sq_stall_stable", 32'(chg), 32'd0);
        chk("sq_stall_rdr", 32'(n_rdr - r0), 32'd1);
        get_words(4, 1'b0, got);
        wait_done();
        for (int k = 0; k < 4; k++) chk($sformatf("sq_r%0d", k), got[k], exp_r(k));
        chk("sq_rdr_total", 32'(n_rdr - r0), 32'd4);

        // Randomised command streams against the reference.
        for (int it = 0; it < 5; it++) begin
            for (int k = 0; k < 14; k++) w[k] = $urandom;
            load_cx(w, 1'b1);
            for (int k = 0; k < 4; k++) w[k] = $urandom;
            absorb(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), w);
            squeeze_check($sformatf("rnd%0d_sq", it), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
            read_c_check($sformatf("rnd%0d_rc", it), 1'b1);
        end

        // Core never returns idle: timeout, sticky err, no reads.
        stuck = 1'b1;
        r0 = n_rdr; c0 = n_rdc;
        issue(2'd2, 4'd0, 4'd5);
        wait_done();
        chk("tmo_err", {31'd0, bus.err}, 32'd1);
        chk("tmo_cycle", 32'(err_rise - start_cyc), 32'd257);
        chk("tmo_busy", {31'd0, bus.busy}, 32'd0);
        chk("tmo_no_reads", 32'(n_rdr - r0 + n_rdc - c0), 32'd0);
        read_c_check("tmo_rc", 1'b0);
        chk("tmo_err_sticky", {31'd0, bus.err}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        chk("tmo_err_cleared", {31'd0, bus.err}, 32'd0);

        // Reset during the 6th C word, then a clean reload.
        for (int k = 0; k < 14; k++) w[k] = 32'hA5000000 | 32'(k);
        issue(2'd0, 4'd0, 4'd0);
        put_words(5, w, 1'b0);
        bus.in_valid = 1'b1; bus.in_data = w[5]; rst = 1'b1;
        @(negedge clk);
        chk("midrst_status", {27'd0, bus.cmd_ready, bus.in_ready, bus.out_valid, bus.busy, bus.err}, 32'd0);
        chk("midrst_strobes", {26'd0, core_wr_c, core_wr_x, core_wr_i, core_start, core_rd_r, core_rd_c}, 32'd0);
        chk("midrst_out_data", bus.out_data, 32'd0);
        rst = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 14; k++) w[k] = $urandom;
        load_cx(w, 1'b0);
        read_c_check("midrst_rc", 1'b0);

        // cmd_valid held across an ABSORB; the queued READ_C is taken once.
        a0 = n_acc;
        for (int k = 0; k < 4; k++) w[k] = $urandom;
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_ds = 4'h2; bus.cmd_rounds = 4'd3;
        t = 0;
        while (!bus.cmd_ready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        bus.cmd_op = 2'd3;
        put_words(4, w, 1'b0);
        for (int k = 0; k < 4; k++) mi[k] = w[k];
        t = 0;
        while (!bus.cmd_ready && t < 200) begin @(negedge clk); t++; end
        chk("held_ready_seen", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("held_ready_at_done", 32'(rdy_rise), 32'(busy_fall));
        get_words(10, 1'b0, got);
        wait_done();
        for (int k = 0; k < 10; k++) chk($sformatf("held_c%0d", k), got[k], mc[k]);
        chk("held_accepts", 32'(n_acc - a0), 32'd2);

        chk("strobes_onehot", 32'(n_multi), 32'd0);
        chk("ready_while_busy", 32'(n_rdy_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
